// File: rtl/rp_trig_edge_det.sv
// rtl/rp_trig_edge_det.sv - per-channel ADC level-crossing trigger with hysteresis and optional holdoff
//
// Purpose:
//   Compares each valid ADC sample against a signed threshold with an unsigned
//   hysteresis band. Each direction arms when the sample leaves the band on the
//   far side and fires one single-cycle pulse when the sample reaches the
//   threshold. Optional holdoff (macro RP_TRIG_HOLDOFF_EN) blanks evaluation
//   for set_holdoff_i clocks after any pulse.
//
// Ports:
//   adc_clk_i      ADC clock
//   adc_rstn_i     synchronous active-low reset
//   adc_dat_i      signed ADC sample (DW bits)
//   adc_dv_i       sample valid strobe
//   set_tresh_i    signed threshold (DW bits)
//   set_hyst_i     unsigned hysteresis (DW bits)
//   set_holdoff_i  holdoff length in clocks (HW bits, ignored without the macro)
//   cfg_clr_i      clears arm flags and holdoff counter, suppresses this cycle's pulse
//   trig_p_o       rising-crossing pulse
//   trig_n_o       falling-crossing pulse
//   state_o        {5'h0, holdoff_busy, arm_n, arm_p}

module rp_trig_edge_det #(
    parameter int DW = 14,
    parameter int HW = 32
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic [DW-1:0] adc_dat_i,
    input  logic          adc_dv_i,
    input  logic [DW-1:0] set_tresh_i,
    input  logic [DW-1:0] set_hyst_i,
    input  logic [HW-1:0] set_holdoff_i,
    input  logic          cfg_clr_i,
    output logic          trig_p_o,
    output logic          trig_n_o,
    output logic [7:0]    state_o
);

    // Two extra bits keep tresh +/- hyst exact for any threshold/hysteresis pair.
    localparam int XW = DW + 2;

    logic signed [XW-1:0] dat_x;
    logic signed [XW-1:0] tresh_x;
    logic signed [XW-1:0] hyst_x;
    logic signed [XW-1:0] lo_x;
    logic signed [XW-1:0] hi_x;

    assign dat_x   = {{2{adc_dat_i[DW-1]}}, adc_dat_i};
    assign tresh_x = {{2{set_tresh_i[DW-1]}}, set_tresh_i};
    assign hyst_x  = {2'b00, set_hyst_i};
    assign lo_x    = tresh_x - hyst_x;
    assign hi_x    = tresh_x + hyst_x;

    logic arm_p_q;
    logic arm_n_q;
    logic trig_p_q;
    logic trig_n_q;
    logic busy_q;

    logic eval;
    logic fire_p;
    logic fire_n;
    logic arm_p_nxt;
    logic arm_n_nxt;
    logic hold_act;
    logic hold_start;
    logic busy_nxt;

`ifdef RP_TRIG_HOLDOFF_EN
    logic [HW-1:0] cnt_q;
    logic [HW-1:0] cnt_nxt;

    // Counter is loaded at the same edge that registers the pulse, so the
    // pulse cycle itself is the first blanked sample.
    assign hold_act   = (cnt_q != '0);
    assign hold_start = (fire_p || fire_n) && (set_holdoff_i != '0);

    always_comb begin
        cnt_nxt = '0;
        if (hold_start) begin
            cnt_nxt = set_holdoff_i;
        end else if (hold_act) begin
            cnt_nxt = cnt_q - {{(HW-1){1'b0}}, 1'b1};
        end
    end

    assign busy_nxt = (cnt_nxt != '0);

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i || cfg_clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end
`else
    logic unused_holdoff;

    assign unused_holdoff = ^set_holdoff_i;
    assign hold_act       = 1'b0;
    assign hold_start     = 1'b0;
    assign busy_nxt       = 1'b0;
`endif

    // Firing looks at the registered arm flags, so one sample can never both
    // arm and fire the same direction.
    always_comb begin
        eval      = adc_dv_i && !hold_act;
        fire_p    = eval && arm_p_q && (dat_x >= tresh_x);
        fire_n    = eval && arm_n_q && (dat_x <= tresh_x);
        arm_p_nxt = arm_p_q;
        arm_n_nxt = arm_n_q;

        if (eval) begin
            if (fire_p) begin
                arm_p_nxt = 1'b0;
            end
            if (fire_n) begin
                arm_n_nxt = 1'b0;
            end
            if (dat_x < lo_x) begin
                arm_p_nxt = 1'b1;
            end
            if (dat_x > hi_x) begin
                arm_n_nxt = 1'b1;
            end
        end

        // Arm flags stay cleared for the whole holdoff window, including the
        // edge that opens it.
        if (hold_start || hold_act) begin
            arm_p_nxt = 1'b0;
            arm_n_nxt = 1'b0;
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i || cfg_clr_i) begin
            arm_p_q  <= 1'b0;
            arm_n_q  <= 1'b0;
            trig_p_q <= 1'b0;
            trig_n_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            arm_p_q  <= arm_p_nxt;
            arm_n_q  <= arm_n_nxt;
            trig_p_q <= fire_p;
            trig_n_q <= fire_n;
            busy_q   <= busy_nxt;
        end
    end

    assign trig_p_o = trig_p_q;
    assign trig_n_o = trig_n_q;
    assign state_o  = {5'h0, busy_q, arm_n_q, arm_p_q};

endmodule
